// File: rtl/tx_lane_sched_if.sv
// Framed 24-bit output stream of the lane scheduler: valid/ready handshake
// plus start-of-frame, end-of-line and end-of-frame qualifiers.
interface tx_lane_sched_if;
  logic [23:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        tx_eol;
  logic        tx_eof;

  modport master (output tx_data, tx_valid, tx_sof, tx_eol, tx_eof, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_sof, tx_eol, tx_eof, output tx_ready);
endinterface

// File: rtl/tx_lane_sched.sv
// Round-robin scheduler for the four camera transmit lanes: emits a sync word,
// then per line a header and interleaved lane samples, pacing each lane advance.
module tx_lane_sched #(
  parameter int          LINE_WORDS  = 160,
  parameter int          FRAME_LINES = 240,
  parameter int          DATA_LAT    = 5,
  parameter logic [23:0] FRAME0      = 24'haa8d55,
  parameter logic [23:0] FRAME1      = 24'haab155,
  parameter logic [7:0]  HSYNC       = 8'h55
) (
  input  logic            Cclk,
  input  logic            rst,
  input  logic [3:0]      TranEn,
  input  logic [47:0]     TranData,
  input  logic            TranFraimSync,
  output logic [3:0]      TranNextData,
  output logic            frame_abort,
  output logic            busy,
  tx_lane_sched_if.master tx
);

  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WAIT_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(DATA_LAT - 1);
  localparam logic [15:0]       LAST_LINE = 16'(FRAME_LINES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, HDR, WAIT, DATA, REARM} state_t;

  state_t            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic              par_q, par_d;
  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [15:0]       line_q, line_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        next_d;
  logic              abort_d;
  logic [11:0]       sample;
  logic              last_lane;
  logic              eol_hit;

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    lowest_lane = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) lowest_lane = 2'(i);
  endfunction

  function automatic logic [1:0] highest_lane(input logic [3:0] m);
    highest_lane = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) highest_lane = 2'(i);
  endfunction

  // Next latched lane above l; wraps to the lowest one past the highest.
  function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] l);
    next_lane = lowest_lane(m);
    for (int i = 3; i >= 0; i--) if (m[i] && (i > int'(l))) next_lane = 2'(i);
  endfunction

  assign sample    = TranEn[lane_q] ? TranData[12*int'(lane_q) +: 12] : 12'h000;
  assign last_lane = (lane_q == highest_lane(mask_q));
  assign eol_hit   = (word_q == LAST_WORD) && last_lane;
  assign busy      = !(state_q inside {IDLE, REARM});

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    mask_d      = mask_q;
    par_d       = par_q;
    lane_d      = lane_q;
    word_d      = word_q;
    line_d      = line_q;
    wait_d      = wait_q;
    next_d      = 4'b0000;
    abort_d     = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 24'h000000;
    tx.tx_sof   = 1'b0;
    tx.tx_eol   = 1'b0;
    tx.tx_eof   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (TranEn != 4'b0000) begin
          mask_d  = TranEn;
          par_d   = TranFraimSync;
          lane_d  = lowest_lane(TranEn);
          line_d  = 16'd0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = par_q ? FRAME1 : FRAME0;
        tx.tx_sof   = 1'b1;
        if (tx.tx_ready) state_d = HDR;
      end
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = {HSYNC, line_q};
        if (tx.tx_ready) begin
          word_d  = '0;
          wait_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == LAST_WAIT) state_d = DATA;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      DATA: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = {lane_q, 10'b0, sample};
        tx.tx_eol   = eol_hit;
        tx.tx_eof   = eol_hit && (line_q == LAST_LINE);
        if (tx.tx_ready) begin
          next_d[lane_q] = TranEn[lane_q];
          lane_d         = next_lane(mask_q, lane_q);
          if (last_lane) word_d = word_q + WORD_W'(1);
          if (eol_hit) begin
            line_d  = line_q + 16'd1;
            state_d = (line_q == LAST_LINE) ? REARM : HDR;
          end else begin
            wait_d  = '0;
            state_d = WAIT;
          end
        end
      end
      REARM: begin
        // Lanes must fully drain before another frame may start.
        if (TranEn == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (busy && (TranEn == 4'b0000)) begin
      state_d = IDLE;
      abort_d = 1'b1;
      next_d  = 4'b0000;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Cclk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= 4'b0000;
      par_q        <= 1'b0;
      lane_q       <= 2'd0;
      word_q       <= '0;
      line_q       <= 16'd0;
      wait_q       <= '0;
      TranNextData <= 4'b0000;
      frame_abort  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      par_q        <= par_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      line_q       <= line_d;
      wait_q       <= wait_d;
      TranNextData <= next_d;
      frame_abort  <= abort_d;
    end
  end

endmodule

// File: tb/tb_tx_lane_sched.sv
// Directed bench for tx_lane_sched with a small frame (2 words x 2 lines):
// full frame, rearm, abort, reset, partial mask and backpressure.
module tb_tx_lane_sched;
  localparam int          LW  = 2;
  localparam int          FL  = 2;
  localparam int          LAT = 5;
  localparam logic [23:0] F0  = 24'haa8d55;
  localparam logic [23:0] F1  = 24'haab155;

  logic        Cclk = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  TranEn = 4'b0000;
  logic [47:0] TranData = {12'h444, 12'h333, 12'h222, 12'h111};
  logic        TranFraimSync = 1'b0;
  logic [3:0]  TranNextData;
  logic        frame_abort;
  logic        busy;

  tx_lane_sched_if tx ();

  tx_lane_sched #(.LINE_WORDS(LW), .FRAME_LINES(FL), .DATA_LAT(LAT)) dut (
    .Cclk          (Cclk),
    .rst           (rst),
    .TranEn        (TranEn),
    .TranData      (TranData),
    .TranFraimSync (TranFraimSync),
    .TranNextData  (TranNextData),
    .frame_abort   (frame_abort),
    .busy          (busy),
    .tx            (tx)
  );

  always #5 Cclk = ~Cclk;

  typedef struct {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    cyc    = 0;
  int    pulses[4] = '{0, 0, 0, 0};
  int    aborts = 0;
  int    tests  = 0;
  int    fails  = 0;

  // Passive monitor on the falling edge: logs transferred beats and pulses.
  always @(negedge Cclk) begin
    cyc++;
    if (tx.tx_valid && tx.tx_ready)
      beats.push_back('{tx.tx_data, tx.tx_sof, tx.tx_eol, tx.tx_eof, cyc});
    for (int i = 0; i < 4; i++) if (TranNextData[i]) pulses[i]++;
    if (frame_abort) aborts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Cclk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      step();
      k++;
    end
    check({tag, " beat count"}, 32'(beats.size()), 32'(n));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (!tx.tx_valid && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(tx.tx_valid), 32'd1);
  endtask

  function automatic logic [31:0] pack(input beat_t b);
    return {5'b0, b.d, b.sof, b.eol, b.eof};
  endfunction

  function automatic logic [23:0] dword(input int ln);
    logic [11:0] s;
    s = 12'h111 * 12'(ln + 1);
    return {2'(ln), 10'b0, s};
  endfunction

  // Expected frame built from the framing rules: sync, then per line a header
  // followed by the latched lanes in ascending order, LW rounds per line.
  task automatic check_frame(input int base, input logic [3:0] mask,
                             input logic [23:0] sync, input string tag);
    int  idx = base;
    int  hi  = 0;
    logic last;
    for (int i = 0; i < 4; i++) if (mask[i]) hi = i;
    check({tag, " sync"}, pack(beats[idx]), {5'b0, sync, 3'b100});
    idx++;
    for (int l = 0; l < FL; l++) begin
      check({tag, " hdr"}, pack(beats[idx]), {5'b0, 8'h55, 16'(l), 3'b000});
      idx++;
      for (int w = 0; w < LW; w++) begin
        for (int ln = 0; ln < 4; ln++) begin
          if (mask[ln]) begin
            last = (w == LW - 1) && (ln == hi);
            check({tag, " data"}, pack(beats[idx]),
                  {5'b0, dword(ln), 1'b0, last, last && (l == FL - 1)});
            idx++;
          end
        end
      end
    end
  endtask

  initial begin
    int p_base[4];
    int base;
    int nb;
    int ab;
    logic [23:0] held;

    tx.tx_ready = 1'b1;
    repeat (3) step();
    check("reset tx_valid", 32'(tx.tx_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset next", 32'(TranNextData), 32'd0);
    check("reset abort", 32'(frame_abort), 32'd0);
    check("reset data", 32'(tx.tx_data), 32'd0);

    // Full frame, all lanes, odd parity.
    rst = 1'b0;
    TranFraimSync = 1'b1;
    for (int i = 0; i < 4; i++) p_base[i] = pulses[i];
    TranEn = 4'hF;
    wait_beats(19, 400, "full");
    repeat (2) step();
    check_frame(0, 4'hF, F1, "full");
    for (int i = 3; i <= 9; i++)
      check("full spacing", 32'(beats[i].cyc - beats[i-1].cyc), 32'(LAT + 1));
    check("full hdr1 spacing", 32'(beats[10].cyc - beats[9].cyc), 32'd1);
    for (int i = 0; i < 4; i++)
      check("full pulses", 32'(pulses[i] - p_base[i]), 32'd4);

    // Rearm: no restart while the enables stay high.
    repeat (20) step();
    check("rearm beats", 32'(beats.size()), 32'd19);
    check("rearm busy", 32'(busy), 32'd0);
    check("rearm valid", 32'(tx.tx_valid), 32'd0);
    TranEn = 4'h0;
    repeat (2) step();
    TranEn = 4'hF;
    wait_beats(20, 10, "rearm restart");
    check("rearm sync", pack(beats[19]), {5'b0, F1, 3'b100});

    // Abort during line 1.
    wait_beats(30, 200, "abort line1");
    check("abort hdr1", 32'(beats[29].d), 32'h550001);
    ab = aborts;
    repeat (2) step();
    TranEn = 4'h0;
    step();
    check("abort pulse", 32'(frame_abort), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(tx.tx_valid), 32'd0);
    step();
    check("abort single", 32'(frame_abort), 32'd0);
    nb = beats.size();
    repeat (10) step();
    check("abort no beats", 32'(beats.size()), 32'(nb));
    check("abort count", 32'(aborts - ab), 32'd1);
    TranEn = 4'hF;
    wait_beats(nb + 1, 10, "abort restart");
    check("abort resync", pack(beats[nb]), {5'b0, F1, 3'b100});

    // Reset in the middle of a data beat.
    wait_beats(nb + 3, 50, "reset first data");
    wait_valid(20, "reset data valid");
    rst = 1'b1;
    step();
    check("midreset valid", 32'(tx.tx_valid), 32'd0);
    check("midreset next", 32'(TranNextData), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    step();
    check("midreset hold", 32'(tx.tx_valid), 32'd0);
    rst = 1'b0;
    step();
    check("postreset sync", {7'b0, tx.tx_valid, tx.tx_data}, {7'b0, 1'b1, F1});
    rst = 1'b1;
    TranEn = 4'h0;
    step();
    rst = 1'b0;
    step();

    // Partial mask, even parity, with backpressure on the second data beat.
    TranFraimSync = 1'b0;
    for (int i = 0; i < 4; i++) p_base[i] = pulses[i];
    base = beats.size();
    TranEn = 4'b1010;
    wait_beats(base + 3, 50, "part first data");
    tx.tx_ready = 1'b0;
    wait_valid(20, "bp valid");
    held = tx.tx_data;
    check("bp word", 32'(held), 32'(dword(3)));
    repeat (6) begin
      step();
      check("bp stable", 32'(tx.tx_data), 32'(dword(3)));
      check("bp no pulse", 32'(TranNextData), 32'd0);
    end
    tx.tx_ready = 1'b1;
    step();
    check("bp release pulse", 32'(TranNextData), 32'h8);
    step();
    check("bp pulse single", 32'(TranNextData), 32'd0);
    wait_beats(base + 11, 300, "part");
    repeat (2) step();
    check_frame(base, 4'b1010, F0, "part");
    check("part pulses l0", 32'(pulses[0] - p_base[0]), 32'd0);
    check("part pulses l1", 32'(pulses[1] - p_base[1]), 32'd4);
    check("part pulses l2", 32'(pulses[2] - p_base[2]), 32'd0);
    check("part pulses l3", 32'(pulses[3] - p_base[3]), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
